// File: rtl/hog_frame_sched_if.sv
// ---------------------------------------------------------------------------
// hog_frame_sched_if
// Bus bundle between the HOG frame scheduler and its neighbours.
//   Pixel memory : mem_rd, mem_addr (scheduler -> memory), mem_rdata (memory -> scheduler)
//   HOG core in  : request (core -> scheduler), ready, i_data (scheduler -> core)
//   HOG core out : o_valid, fea (core -> scheduler)
//   Feature buf  : fea_wr, fea_waddr, fea_wdata (scheduler -> buffer)
// Modport master is the scheduler side; slave is the environment side.
// ---------------------------------------------------------------------------
interface hog_frame_sched_if #(
    parameter int PIX_W   = 8,
    parameter int FEA_W   = 12,
    parameter int ADDR_W  = 16,
    parameter int FADDR_W = 12
);
    logic                 mem_rd;
    logic [ADDR_W-1:0]    mem_addr;
    logic [4*PIX_W-1:0]   mem_rdata;
    logic                 request;
    logic                 ready;
    logic [4*PIX_W-1:0]   i_data;
    logic                 o_valid;
    logic [FEA_W-1:0]     fea;
    logic                 fea_wr;
    logic [FADDR_W-1:0]   fea_waddr;
    logic [FEA_W-1:0]     fea_wdata;

    modport master (
        output mem_rd, mem_addr, ready, i_data, fea_wr, fea_waddr, fea_wdata,
        input  mem_rdata, request, o_valid, fea
    );

    modport slave (
        input  mem_rd, mem_addr, ready, i_data, fea_wr, fea_waddr, fea_wdata,
        output mem_rdata, request, o_valid, fea
    );
endinterface

// File: rtl/hog_frame_sched.sv
// ---------------------------------------------------------------------------
// hog_frame_sched
// Frame-level controller for the HOG pipeline. On start it streams cfg_words
// 4-pixel words from a synchronous pixel memory into the HOG core (one word
// per core request), captures every feature the core emits into a feature
// buffer, and reports done / err.
// Ports:
//   clk, rst (sync, active-low)
//   start, abort          frame control
//   cfg_words/feas/tmo    frame configuration, sampled on accepted start
//   busy, done, err       status
//   bus (master)          pixel memory, HOG core and feature buffer signals
// ---------------------------------------------------------------------------
module hog_frame_sched #(
    parameter int PIX_W   = 8,
    parameter int FEA_I   = 4,
    parameter int FEA_F   = 8,
    parameter int ADDR_W  = 16,
    parameter int FADDR_W = 12,
    parameter int TO_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   cfg_words,
    input  logic [FADDR_W-1:0]  cfg_feas,
    input  logic [TO_W-1:0]     cfg_tmo,
    output logic                busy,
    output logic                done,
    output logic                err,
    hog_frame_sched_if.master   bus
);
    localparam int IN_W  = 4 * PIX_W;
    localparam int FEA_W = FEA_I + FEA_F;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_READ, S_PUSH, S_DRAIN, S_DONE
    } state_t;

    state_t               r_state, w_state_next;
    logic [ADDR_W-1:0]    r_cfg_words, r_wcnt;
    logic [FADDR_W-1:0]   r_cfg_feas, r_fcnt, r_fea_waddr;
    logic [TO_W-1:0]      r_cfg_tmo, r_tcnt, w_tcnt_inc;
    logic [IN_W-1:0]      r_i_data;
    logic [FEA_W-1:0]     r_fea_wdata;
    logic                 r_ready, r_fea_wr, r_err;
    logic                 w_capture, w_timeout, w_last_word;

    assign w_tcnt_inc  = r_tcnt + TO_W'(1);
    assign w_last_word = (r_wcnt + ADDR_W'(1)) == r_cfg_words;

    // Features are accepted in every active streaming/draining state.
    assign w_capture = bus.o_valid && !abort &&
                       ((r_state == S_FETCH) || (r_state == S_READ) ||
                        (r_state == S_PUSH)  || (r_state == S_DRAIN));

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_state_next = (cfg_words == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (bus.request) w_state_next = S_READ;
            S_READ:  w_state_next = S_PUSH;
            S_PUSH:  w_state_next = w_last_word ? S_DRAIN : S_FETCH;
            S_DRAIN: begin
                // All expected features wins over a simultaneous timeout.
                // The timeout counts the current idle cycle, so it fires once
                // cfg_tmo consecutive DRAIN cycles have passed without o_valid.
                if (r_fcnt == r_cfg_feas) begin
                    w_state_next = S_DONE;
                end else if (!bus.o_valid && (w_tcnt_inc == r_cfg_tmo)) begin
                    w_state_next = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (abort) begin
            w_state_next = S_IDLE;
            w_timeout    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cfg_words <= '0;
            r_cfg_feas  <= '0;
            r_cfg_tmo   <= '0;
            r_wcnt      <= '0;
            r_fcnt      <= '0;
            r_tcnt      <= '0;
            r_i_data    <= '0;
            r_ready     <= 1'b0;
            r_fea_wr    <= 1'b0;
            r_fea_waddr <= '0;
            r_fea_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_ready  <= 1'b0;
            r_fea_wr <= w_capture;

            if (w_capture) begin
                r_fea_wdata <= bus.fea;
                r_fea_waddr <= r_fcnt;
                r_fcnt      <= r_fcnt + FADDR_W'(1);
            end

            // Idle-cycle counter only runs while draining.
            if ((r_state == S_DRAIN) && !bus.o_valid) begin
                r_tcnt <= w_tcnt_inc;
            end else begin
                r_tcnt <= '0;
            end

            if (!abort) begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_cfg_words <= cfg_words;
                        r_cfg_feas  <= cfg_feas;
                        r_cfg_tmo   <= cfg_tmo;
                        r_wcnt      <= '0;
                        r_fcnt      <= '0;
                        r_err       <= (cfg_words == '0);
                    end
                    S_READ: begin
                        r_i_data <= bus.mem_rdata;
                        r_ready  <= 1'b1;
                    end
                    S_PUSH:  r_wcnt <= r_wcnt + ADDR_W'(1);
                    S_DRAIN: if (w_timeout) r_err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.mem_rd    = (r_state == S_FETCH) && bus.request && !abort;
    assign bus.mem_addr  = r_wcnt;
    assign bus.ready     = r_ready;
    assign bus.i_data    = r_i_data;
    assign bus.fea_wr    = r_fea_wr;
    assign bus.fea_waddr = r_fea_waddr;
    assign bus.fea_wdata = r_fea_wdata;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign err           = r_err;
endmodule
